// File: rtl/multdiv_issue_ctrl.sv
// Initiator-side controller for the slow multiply/divide unit.
// Accepts MUL/MULH/DIV/REM commands on a valid/ready stream and drives the unit's
// enable, select and operand inputs. Also owns the shared 33-bit adder, the
// equal-to-zero flag and the two 34-bit intermediate-value registers. Returns the
// result on a valid/ready response stream.
// Optional build macro: MULTDIV_ISSUE_CYCLE_CNT_EN adds an issue-to-valid cycle
// counter on rsp_cycles_o. When the macro is undefined, rsp_cycles_o is tied to 0.
module multdiv_issue_ctrl #(
  parameter bit DATA_IND_TIMING = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // command stream
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [1:0]  cmd_signed_i,
  input  logic [31:0] cmd_op_a_i,
  input  logic [31:0] cmd_op_b_i,
  // response stream
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [7:0]  rsp_cycles_o,
  // unit control
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        data_ind_timing_o,
  output logic        multdiv_ready_id_o,
  // borrowed adder
  input  logic [32:0] alu_operand_a_i,
  input  logic [32:0] alu_operand_b_i,
  output logic [33:0] alu_adder_ext_o,
  output logic [31:0] alu_adder_o,
  output logic        equal_to_zero_o,
  // borrowed intermediate registers
  input  logic [67:0] imd_val_d_i,
  input  logic [1:0]  imd_val_we_i,
  output logic [67:0] imd_val_q_o,
  // unit result
  input  logic [31:0] multdiv_result_i,
  input  logic        valid_i
);

  // StDoneWait: the unit has its result but the response slot is still full.
  typedef enum logic [1:0] {StIdle, StBusy, StDoneWait} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [67:0] imd_q, imd_d;

  logic        unit_active;
  logic        ready_id;
  logic        cmd_accept;
  logic        capture;

  // Shared adder: purely combinational, no register towards the unit.
  assign alu_adder_ext_o = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
  assign alu_adder_o     = alu_adder_ext_o[32:1];
  assign equal_to_zero_o = (alu_adder_o == 32'h0);

  // Intermediate register next values: per-half write enables, independent of FSM.
  always_comb begin
    imd_d = imd_q;
    if (imd_val_we_i[0]) imd_d[33:0]  = imd_val_d_i[33:0];
    if (imd_val_we_i[1]) imd_d[67:34] = imd_val_d_i[67:34];
  end

  // Intermediate register storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) imd_q <= '0;
    else       imd_q <= imd_d;
  end

  assign imd_val_q_o = imd_q;

  // Handshake decode shared by the FSM and the datapath.
  always_comb begin
    unit_active = (state_q != StIdle);
    ready_id    = !rsp_valid_q || rsp_ready_i;
    // Accept only when the unit is idle; a pending response does not block issue.
    cmd_ready_o = (state_q == StIdle);
    cmd_accept  = cmd_valid_i && cmd_ready_o;
    capture     = unit_active && valid_i && ready_id;
  end

  // Next state, command latch and response slot.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sgn_d       = sgn_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          op_d    = cmd_op_i;
          sgn_d   = cmd_signed_i;
          a_d     = cmd_op_a_i;
          b_d     = cmd_op_b_i;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (valid_i) state_d = ready_id ? StIdle : StDoneWait;
      end
      StDoneWait: begin
        if (valid_i && ready_id) state_d = StIdle;
        else if (!valid_i)       state_d = StBusy;
      end
      default: state_d = StIdle;
    endcase

    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    // A capture in the same cycle as a consume keeps the slot full.
    if (capture) begin
      rsp_valid_d = 1'b1;
      result_d    = multdiv_result_i;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= '0;
      sgn_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sgn_q       <= sgn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign mult_en_o          = unit_active && !op_q[1];
  assign div_en_o           = unit_active && op_q[1];
  assign mult_sel_o         = mult_en_o;
  assign div_sel_o          = div_en_o;
  assign operator_o         = op_q;
  assign signed_mode_o      = sgn_q;
  assign op_a_o             = a_q;
  assign op_b_o             = b_q;
  assign data_ind_timing_o  = DATA_IND_TIMING;
  assign multdiv_ready_id_o = ready_id;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_result_o       = result_q;

`ifdef MULTDIV_ISSUE_CYCLE_CNT_EN
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] cycles_q, cycles_d;

  // Cycle counter: cleared on accept, counts BUSY cycles including the capture cycle.
  always_comb begin
    cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    if (cmd_accept)              cnt_d = '0;
    else if (state_q == StBusy)  cnt_d = cnt_inc;
    if (capture) cycles_d = (state_q == StBusy) ? cnt_inc : cnt_q;
  end

  // Counter and latched latency registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign rsp_cycles_o = cycles_q;
`else
  assign rsp_cycles_o = 8'h00;
`endif

endmodule
